// File: rtl/parking_input_ctrl_if.sv
// Raw switch inputs and debounced event outputs of the parking input controller.
interface parking_input_ctrl_if;
  logic       car_enter_raw;
  logic       car_exit_raw;
  logic [2:0] car_sel_raw;
  logic       car_enter;
  logic       car_exit;
  logic [2:0] car_sel;
  logic       err_sel;
  logic       err_both;
  logic [7:0] event_count;

  modport master (
    output car_enter_raw, car_exit_raw, car_sel_raw,
    input  car_enter, car_exit, car_sel, err_sel, err_both, event_count
  );

  modport slave (
    input  car_enter_raw, car_exit_raw, car_sel_raw,
    output car_enter, car_exit, car_sel, err_sel, err_both, event_count
  );
endinterface

// File: rtl/parking_input_ctrl.sv
// Synchronize + debounce parking switches and turn them into one-cycle enter/exit pulses;
// raw-to-pulse latency 2+DB_CYCLES+1, no backpressure. PARKING_EVENT_COUNT_EN adds the event counter.
module parking_input_ctrl #(
  parameter int unsigned DB_CYCLES = 16
) (
  input logic                  clk,
  input logic                  reset,
  parking_input_ctrl_if.slave  io
);

  typedef enum logic [1:0] {IDLE, FIRE, WAIT_REL} state_t;

  localparam int CW = 16;
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  // bit 0 = enter, bit 1 = exit, bits 4:2 = slot select
  logic [4:0]    sync1_q, sync1_d, sync2_q, sync2_d, db_q, db_d;
  logic [CW-1:0] cnt_q [5];
  logic [CW-1:0] cnt_d [5];

  state_t     state_q, state_d;
  logic       dir_exit_q, dir_exit_d;
  logic [2:0] pend_sel_q, pend_sel_d;
  logic       car_enter_q, car_enter_d;
  logic       car_exit_q, car_exit_d;
  logic [2:0] car_sel_q, car_sel_d;
  logic       err_sel_q, err_sel_d;
  logic       err_both_q, err_both_d;

  logic [1:0] rise;
  logic [2:0] sel_new;
  logic       sel_one_hot;

  always_comb begin
    sync1_d = {io.car_sel_raw, io.car_exit_raw, io.car_enter_raw};
    sync2_d = sync1_q;
    for (int i = 0; i < 5; i++) begin
      db_d[i]  = db_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_LAST) db_d[i] = sync2_q[i];
        else                     cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Edges are taken from the next debounced value so the FSM reaches FIRE on the same edge
  // the debounced bit flips, keeping the pulse at 2+DB_CYCLES+1 cycles after the raw change.
  assign rise        = db_d[1:0] & ~db_q[1:0];
  assign sel_new     = db_d[4:2];
  assign sel_one_hot = (sel_new == 3'b001) || (sel_new == 3'b010) || (sel_new == 3'b100);

  always_comb begin
    state_d     = state_q;
    dir_exit_d  = dir_exit_q;
    pend_sel_d  = pend_sel_q;
    car_enter_d = 1'b0;
    car_exit_d  = 1'b0;
    car_sel_d   = car_sel_q;
    err_sel_d   = err_sel_q;
    err_both_d  = err_both_q;
    case (state_q)
      IDLE: begin
        if (rise != 2'b00) begin
          if (db_d[0] && db_d[1]) begin
            err_both_d = 1'b1;
            state_d    = WAIT_REL;
          end else if (!sel_one_hot) begin
            err_sel_d = 1'b1;
            state_d   = WAIT_REL;
          end else begin
            dir_exit_d = rise[1];
            pend_sel_d = sel_new;
            state_d    = FIRE;
          end
        end
      end
      FIRE: begin
        car_enter_d = ~dir_exit_q;
        car_exit_d  = dir_exit_q;
        car_sel_d   = pend_sel_q;
        state_d     = WAIT_REL;
      end
      WAIT_REL: begin
        if (db_q[1:0] == 2'b00) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      db_q        <= '0;
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
      state_q     <= IDLE;
      dir_exit_q  <= 1'b0;
      pend_sel_q  <= 3'b000;
      car_enter_q <= 1'b0;
      car_exit_q  <= 1'b0;
      car_sel_q   <= 3'b000;
      err_sel_q   <= 1'b0;
      err_both_q  <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      db_q        <= db_d;
      for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
      state_q     <= state_d;
      dir_exit_q  <= dir_exit_d;
      pend_sel_q  <= pend_sel_d;
      car_enter_q <= car_enter_d;
      car_exit_q  <= car_exit_d;
      car_sel_q   <= car_sel_d;
      err_sel_q   <= err_sel_d;
      err_both_q  <= err_both_d;
    end
  end

  assign io.car_enter = car_enter_q;
  assign io.car_exit  = car_exit_q;
  assign io.car_sel   = car_sel_q;
  assign io.err_sel   = err_sel_q;
  assign io.err_both  = err_both_q;

`ifdef PARKING_EVENT_COUNT_EN
  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (state_q == FIRE) count_d = count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= 8'd0;
    else       count_q <= count_d;
  end

  assign io.event_count = count_q;
`else
  assign io.event_count = 8'd0;
`endif

endmodule

// File: tb/tb_parking_input_ctrl.sv
// Directed bench for parking_input_ctrl with DB_CYCLES=4.
module tb_parking_input_ctrl;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  parking_input_ctrl_if pif ();

  parking_input_ctrl #(.DB_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (pif)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_en  = 0;
  int n_ex  = 0;

  typedef struct {
    logic       en;
    logic       ex;
    logic [2:0] sel;
    int         hold;
    int         exp_en;
    int         exp_ex;
    logic [2:0] exp_sel;
    logic       exp_err_sel;
    logic       exp_err_both;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      n_en += int'(pif.car_enter);
      n_ex += int'(pif.car_exit);
    end
  endtask

  task automatic do_reset();
    reset             = 1'b1;
    pif.car_enter_raw = 1'b0;
    pif.car_exit_raw  = 1'b0;
    pif.car_sel_raw   = 3'b000;
    step(3);
    reset = 1'b0;
    n_en  = 0;
    n_ex  = 0;
  endtask

  function automatic int exp_cnt(input int events);
`ifdef PARKING_EVENT_COUNT_EN
    return events % 256;
`else
    return 0 + (events & 0);
`endif
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_enter"},    int'(pif.car_enter),   0);
    chk({tag, "_exit"},     int'(pif.car_exit),    0);
    chk({tag, "_sel"},      int'(pif.car_sel),     0);
    chk({tag, "_err_sel"},  int'(pif.err_sel),     0);
    chk({tag, "_err_both"}, int'(pif.err_both),    0);
    chk({tag, "_count"},    int'(pif.event_count), 0);
  endtask

  initial begin
    int first;
    int db_seen;

    vecs[0]  = '{1'b1, 1'b0, 3'b010, 20, 1, 0, 3'b010, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 3'b001, 20, 0, 1, 3'b001, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 3'b100, 20, 0, 1, 3'b100, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 3'b000, 20, 0, 0, 3'b000, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 3'b011, 20, 0, 0, 3'b000, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 3'b101, 20, 0, 0, 3'b000, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 3'b110, 20, 0, 0, 3'b000, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 3'b111, 20, 0, 0, 3'b000, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 3'b100, 20, 0, 0, 3'b000, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 3'b011, 20, 0, 0, 3'b000, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 3'b001, 50, 1, 0, 3'b001, 1'b0, 1'b0};

    pif.car_enter_raw = 1'b1;
    pif.car_exit_raw  = 1'b1;
    pif.car_sel_raw   = 3'b010;
    step(3);
    chk_all_zero("in_reset");

    for (int v = 0; v < 11; v++) begin
      do_reset();
      pif.car_sel_raw = vecs[v].sel;
      step(10);
      pif.car_enter_raw = vecs[v].en;
      pif.car_exit_raw  = vecs[v].ex;
      step(vecs[v].hold);
      pif.car_enter_raw = 1'b0;
      pif.car_exit_raw  = 1'b0;
      step(12);
      chk($sformatf("vec%0d_enter_pulses", v), n_en, vecs[v].exp_en);
      chk($sformatf("vec%0d_exit_pulses", v),  n_ex, vecs[v].exp_ex);
      chk($sformatf("vec%0d_car_sel", v),  int'(pif.car_sel),  int'(vecs[v].exp_sel));
      chk($sformatf("vec%0d_err_sel", v),  int'(pif.err_sel),  int'(vecs[v].exp_err_sel));
      chk($sformatf("vec%0d_err_both", v), int'(pif.err_both), int'(vecs[v].exp_err_both));
      chk($sformatf("vec%0d_count", v), int'(pif.event_count), exp_cnt(vecs[v].exp_en + vecs[v].exp_ex));
    end

    // Pulse lands exactly 7 cycles after the raw edge, one cycle wide.
    do_reset();
    pif.car_sel_raw = 3'b010;
    step(10);
    pif.car_enter_raw = 1'b1;
    first = -1;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      if (pif.car_enter && first < 0) begin
        first = k;
        chk("lat_car_sel", int'(pif.car_sel), 3'b010);
        chk("lat_count", int'(pif.event_count), exp_cnt(1));
      end
    end
    chk("lat_cycle", first, 7);
    chk("lat_pulses", n_en, 1);

    // Fast bouncing never reaches the debounce threshold.
    do_reset();
    pif.car_sel_raw = 3'b010;
    step(10);
    db_seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (k % 2 == 0) pif.car_enter_raw = ~pif.car_enter_raw;
      step(1);
      db_seen |= int'(dut.db_q[0]);
    end
    pif.car_enter_raw = 1'b0;
    step(8);
    chk("bounce_db", db_seen, 0);
    chk("bounce_pulses", n_en, 0);

    // Illegal sel rejected, then a legal exit accepted; err_sel stays sticky.
    do_reset();
    pif.car_sel_raw = 3'b011;
    step(10);
    pif.car_exit_raw = 1'b1;
    step(12);
    chk("selerr_pulses", n_ex, 0);
    chk("selerr_flag", int'(pif.err_sel), 1);
    pif.car_exit_raw = 1'b0;
    step(10);
    pif.car_sel_raw = 3'b001;
    step(10);
    pif.car_exit_raw = 1'b1;
    step(12);
    chk("selerr_exit_pulses", n_ex, 1);
    chk("selerr_car_sel", int'(pif.car_sel), 3'b001);
    chk("selerr_sticky", int'(pif.err_sel), 1);

    // Both switches together: err_both, FSM held in WAIT_REL until both released.
    do_reset();
    pif.car_sel_raw = 3'b100;
    step(10);
    pif.car_enter_raw = 1'b1;
    pif.car_exit_raw  = 1'b1;
    step(12);
    chk("both_pulses", n_en + n_ex, 0);
    chk("both_flag", int'(pif.err_both), 1);
    pif.car_exit_raw = 1'b0;
    step(12);
    chk("both_wait_one_high", int'(dut.state_q), 2);
    pif.car_enter_raw = 1'b0;
    step(6);
    chk("both_wait_db", int'(dut.state_q), 2);
    step(1);
    chk("both_idle", int'(dut.state_q), 0);
    pif.car_enter_raw = 1'b1;
    step(12);
    chk("both_then_enter", n_en, 1);
    chk("both_car_sel", int'(pif.car_sel), 3'b100);
    chk("both_sticky", int'(pif.err_both), 1);
    pif.car_enter_raw = 1'b0;

    // Long hold gives a single pulse; re-press gives another.
    do_reset();
    pif.car_sel_raw = 3'b001;
    step(10);
    pif.car_enter_raw = 1'b1;
    step(50);
    chk("hold_pulses", n_en, 1);
    pif.car_enter_raw = 1'b0;
    step(12);
    pif.car_enter_raw = 1'b1;
    step(12);
    chk("repress_pulses", n_en, 2);
    pif.car_enter_raw = 1'b0;

    // Reset in the FIRE cycle kills the pulse; a switch held through reset fires afterwards.
    do_reset();
    pif.car_sel_raw = 3'b010;
    step(10);
    pif.car_enter_raw = 1'b1;
    step(6);
    chk("fire_state", int'(dut.state_q), 1);
    reset = 1'b1;
    step(1);
    chk_all_zero("fire_reset");
    chk("fire_reset_pulses", n_en, 0);
    step(1);
    reset = 1'b0;
    first = -1;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      if (pif.car_enter && first < 0) first = k;
    end
    chk("held_through_reset_cycle", first, 7);
    chk("held_through_reset_sel", int'(pif.car_sel), 3'b010);
    pif.car_enter_raw = 1'b0;

    // 256 accepted events wrap the counter back to 0.
    do_reset();
    pif.car_sel_raw = 3'b001;
    step(10);
    for (int i = 0; i < 256; i++) begin
      pif.car_enter_raw = 1'b1;
      step(10);
      pif.car_enter_raw = 1'b0;
      step(10);
      if (i == 254) chk("count_255", int'(pif.event_count), exp_cnt(255));
    end
    chk("wrap_pulses", n_en, 256);
    chk("wrap_count", int'(pif.event_count), exp_cnt(256));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parking_input_ctrl.md
PARKING_INPUT_CTRL -- requirements
Module: parking_input_ctrl

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 16, the number of consecutive stable cycles needed to accept a switch change (legal range 2..65535).
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock. All state is updated on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port car_enter_raw, input, 1 bit: raw enter switch, asynchronous to clk.
REQ-005 The block SHALL have port car_exit_raw, input, 1 bit: raw exit switch, asynchronous to clk.
REQ-006 The block SHALL have port car_sel_raw, input, 3 bits: raw slot-select switches, where a one-hot value is legal.
REQ-007 The block SHALL have port car_enter, output, 1 bit: a one-cycle enter event pulse for the car enter/exit stage.
REQ-008 The block SHALL have port car_exit, output, 1 bit: a one-cycle exit event pulse.
REQ-009 The block SHALL have port car_sel, output, 3 bits: the registered one-hot slot, valid whenever a pulse is high and held until the next accepted event.
REQ-010 The block SHALL have port err_sel, output, 1 bit: a sticky flag meaning an event was rejected because car_sel was not one-hot.
REQ-011 The block SHALL have port err_both, output, 1 bit: a sticky flag meaning an event was rejected because enter and exit were both debounced high.
REQ-012 The block SHALL have port event_count, output, 8 bits: the number of accepted events (see Configuration).

Function
REQ-013 Each of the 5 raw inputs SHALL pass through a 2-flop synchronizer before any other logic.
REQ-014 Each synchronized bit SHALL have its own debounce counter, and the debounced value SHALL change only after the synchronized value has differed from it for exactly DB_CYCLES consecutive cycles.
REQ-015 Any cycle in which the synchronized value matches the debounced value SHALL clear that bit's counter.
REQ-016 The FSM SHALL have three states: IDLE, FIRE and WAIT_REL.
REQ-017 In IDLE, a debounced rising edge on enter or exit SHALL be evaluated as a candidate event.
REQ-018 A candidate event SHALL be accepted, moving the FSM to FIRE, only if debounced sel is one-hot and the other direction switch is debounced low.
REQ-019 In FIRE, exactly one of car_enter or car_exit SHALL be high for exactly one cycle, car_sel SHALL be loaded with debounced sel in that same cycle, and the FSM SHALL then go to WAIT_REL.
REQ-020 In WAIT_REL, the FSM SHALL return to IDLE only once debounced enter and exit are both low, and all edges seen in WAIT_REL SHALL be ignored.
REQ-021 A candidate event with non-one-hot sel (000, 011, 101, 110, 111) SHALL set err_sel, produce no pulse, and move the FSM to WAIT_REL.
REQ-022 Enter and exit rising edges in the same cycle, or an edge while the opposite switch is debounced high, SHALL set err_both, produce no pulse, and move the FSM to WAIT_REL.
REQ-023 Latency from a raw change to the pulse SHALL be 2 + DB_CYCLES + 1 cycles.
REQ-024 Changes on sel after an event is accepted SHALL NOT alter the car_sel output until the next accepted event.
REQ-025 err_sel and err_both SHALL clear only on reset.

Reset
REQ-026 While reset is high, all synchronizers, debounced values and counters SHALL be 0, and the FSM SHALL be in IDLE.
REQ-027 While reset is high, car_enter, car_exit, err_sel and err_both SHALL be 0, car_sel SHALL be 3'b000, and event_count SHALL be 0.
REQ-028 A reset asserted during FIRE SHALL suppress the pulse in that cycle.
REQ-029 A switch already held high when reset releases SHALL produce a debounced rising edge and therefore an event once DB_CYCLES is satisfied.

Configuration
REQ-030 Macro PARKING_EVENT_COUNT_EN SHALL control the event counter.
REQ-031 With PARKING_EVENT_COUNT_EN defined, event_count SHALL increment by 1 on every FIRE cycle and wrap from 255 to 0.
REQ-032 Without PARKING_EVENT_COUNT_EN, the port SHALL remain present, event_count SHALL be tied to 8'd0, and no counter logic SHALL be generated.

Verification (DB_CYCLES=4)
REQ-033 Bench SHALL check: sel=3'b010, enter raised and held -> car_enter high for exactly 1 cycle, 7 cycles after the raw edge, with car_sel=3'b010 and event_count=1.
REQ-034 Bench SHALL check: enter toggled every 2 cycles for 20 cycles -> no pulse, and the debounced value stays 0.
REQ-035 Bench SHALL check: sel=3'b011, exit raised -> no pulse and err_sel=1; after exit drops, sel=3'b001 and exit raised -> car_exit pulse with car_sel=3'b001.
REQ-036 Bench SHALL check: enter and exit raised in the same cycle with sel=3'b100 -> no pulse, err_both=1, and the FSM stays in WAIT_REL until both are low for 4 cycles.
REQ-037 Bench SHALL check: enter held high continuously for 50 cycles -> exactly one pulse; after release and re-press, a second pulse occurs.
REQ-038 Bench SHALL check: reset asserted in the FIRE cycle -> car_enter stays 0 and all outputs are 0 on the next cycle; with PARKING_EVENT_COUNT_EN defined, 256 events -> event_count=0.
